// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, returns {remainder, quotient} after WIDTH cycles.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor completes directly from IDLE with the closed-form result.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_div,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_div
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rq_q, rq_d, result_q, result_d, step;
    logic [WIDTH-1:0] dvs_q, dvs_d, mag_a, mag_b;
    logic [WIDTH:0] rem_x, diff;
    logic sgn_q, sgn_d, na_q, na_d, nb_q, nb_d, ready_q, ready_d;

    function automatic logic [2*WIDTH-1:0] fix(input logic [2*WIDTH-1:0] v, input logic s,
                                               input logic neg_a, input logic neg_b);
        logic [WIDTH-1:0] r, q;
        r = v[2*WIDTH-1:WIDTH];
        q = v[WIDTH-1:0];
        return {(s & neg_a) ? -r : r, (s & (neg_a ^ neg_b)) ? -q : q};
    endfunction

    always_comb begin
        mag_a = (signed_div & a[WIDTH-1]) ? -a : a;
        mag_b = (signed_div & b[WIDTH-1]) ? -b : b;
        rem_x = rq_q[2*WIDTH-1:WIDTH-1];
        diff = rem_x - {1'b0, dvs_q};
        step = diff[WIDTH] ? {rq_q[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};
        state_d = state_q;
        cnt_d = cnt_q;
        rq_d = rq_q;
        dvs_d = dvs_q;
        sgn_d = sgn_q;
        na_d = na_q;
        nb_d = nb_q;
        result_d = result_q;
        ready_d = 1'b0;
        if (annul) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    rq_d = {{WIDTH{1'b0}}, mag_a};
                    dvs_d = mag_b;
                    sgn_d = signed_div;
                    na_d = a[WIDTH-1];
                    nb_d = b[WIDTH-1];
                    cnt_d = '0;
                    state_d = BUSY;
`ifdef DIV_ZERO_SHORTCUT_EN
                    if (b == '0) begin
                        state_d = DONE;
                        result_d = fix({mag_a, {WIDTH{1'b1}}}, signed_div, a[WIDTH-1], 1'b0);
                        ready_d = 1'b1;
                    end
`endif
                end
                BUSY: begin
                    rq_d = step;
                    cnt_d = cnt_q + 1'b1;
                    // the final quotient bit is folded straight into the corrected result
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        result_d = fix(step, sgn_q, na_q, nb_q);
                        ready_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rq_q <= '0;
            dvs_q <= '0;
            sgn_q <= 1'b0;
            na_q <= 1'b0;
            nb_q <= 1'b0;
            result_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rq_q <= rq_d;
            dvs_q <= dvs_d;
            sgn_q <= sgn_d;
            na_q <= na_d;
            nb_q <= nb_d;
            result_q <= result_d;
            ready_q <= ready_d;
        end
    end

    assign result = result_q;
    assign ready = ready_q;
    assign stall_div = ~rst & (((state_q == IDLE) & start & ~annul) | (state_q == BUSY));
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divides with a scoreboard; a monitor checks each ready pulse against queued expectations.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        signed_div, start, annul;
    logic [63:0] result;
    logic        ready, stall_div;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [63:0] last_res = 64'h0;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;
    exp_t sb[$];

`ifdef DIV_ZERO_SHORTCUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div), .start(start),
        .annul(annul), .result(result), .ready(ready), .stall_div(stall_div)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ready) begin
            chk("ready_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                           input logic [63:0] exp_v, input int lat);
        int t0;
        a = ta;
        b = tbv;
        signed_div = ts;
        start = 1'b1;
        t0 = cyc;
        sb.push_back(exp_t'{exp_v, t0 + lat});
        for (int k = 0; k <= lat; k++) begin
            #1;
            chk("stall_div", 64'(stall_div), 64'(k < lat));
            if (k == lat) start = 1'b0;
            @(negedge clk);
        end
        last_res = exp_v;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        annul = 1'b0;
        a = 32'd0;
        b = 32'd0;
        signed_div = 1'b0;
        #1;
        chk("rst_stall", 64'(stall_div), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'h0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33);
        run_div(32'h12345678, 32'd0, 1'b0, 64'h12345678_FFFFFFFF, ZLAT);
        run_div(32'hFFFFFFFB, 32'd0, 1'b1, 64'hFFFFFFFB_00000001, ZLAT);
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
        run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33);
        run_div(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 33);
        run_div(32'd5, 32'd10, 1'b0, 64'h00000005_00000000, 33);
        run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, 33);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 33);

        // annul mid-operation, then a fresh divide two cycles later
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1 chk("annul_c10_stall", 64'(stall_div), 64'd1);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        chk("annul_c11_stall", 64'(stall_div), 64'd0);
        chk("annul_c11_ready", 64'(ready), 64'd0);
        chk("annul_c11_result", result, last_res);
        @(negedge clk);
        run_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 33);

        // annul coinciding with the final iteration
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
        repeat (32) @(negedge clk);
        annul = 1'b1;
        #1 chk("annul_last_stall", 64'(stall_div), 64'd1);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        chk("annul_last_ready", 64'(ready), 64'd0);
        chk("annul_last_stall_after", 64'(stall_div), 64'd0);
        chk("annul_last_result", result, last_res);
        @(negedge clk);

        // asynchronous reset mid-operation
        a = 32'd77; b = 32'd4; signed_div = 1'b0; start = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_result", result, 64'h0);
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_stall", 64'(stall_div), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("post_rst_stall", 64'(stall_div), 64'd0);
        chk("post_rst_ready", 64'(ready), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
